// File: rtl/spot_finder_pkg.sv
// Shared definitions for the spot finder datapath: capture FSM states and RAM geometry.
package spot_finder_pkg;

    localparam int PIXELS_PER_WORD = 32;
    localparam int ADDR_W          = 14;
    localparam int RAM_WORD_W      = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_packer.sv
// Packs a stream of 8-bit pixels into one RAM word; pixel 0 lands in the LSB byte.
module pixel_packer #(
    parameter int PIXELS_PER_WORD = spot_finder_pkg::PIXELS_PER_WORD
) (
    input  logic                                  clk_in,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic [7:0]                            pixel_in,
    input  logic                                  pixel_valid,
    output logic [spot_finder_pkg::RAM_WORD_W-1:0] pack_word,
    output logic                                  word_full
);
    import spot_finder_pkg::*;

    localparam int CNT_W = $clog2(PIXELS_PER_WORD);

    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pix_idx;

    // A clear coinciding with a valid pixel makes that pixel index 0 of a fresh word.
    assign pix_idx   = clear ? '0 : pix_cnt;
    assign word_full = pixel_valid && (pix_idx == CNT_W'(PIXELS_PER_WORD - 1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pix_cnt   <= '0;
            pack_word <= '0;
        end else if (pixel_valid) begin
            pack_word[{pix_idx, 3'b000} +: 8] <= pixel_in;
            pix_cnt <= word_full ? '0 : pix_idx + 1'b1;
        end else if (clear) begin
            pix_cnt <= '0;
        end
    end

endmodule

// File: rtl/spot_ram_writer.sv
// Captures one camera frame into the spot RAM as packed kernels and hands it to the consumer.
//   state      | meaning
//   ST_IDLE    | waiting for frame_start, pixels ignored
//   ST_CAPTURE | packing pixels, one RAM write per full kernel
//   ST_DONE    | frame complete in RAM, held until frame_ack
module spot_ram_writer #(
    parameter int PIXELS_PER_WORD = spot_finder_pkg::PIXELS_PER_WORD,
    parameter int ADDR_W          = spot_finder_pkg::ADDR_W
) (
    input  logic                                  clk_in,
    input  logic                                  reset,
    input  logic [7:0]                            pixel_in,
    input  logic                                  pixel_valid,
    input  logic                                  frame_start,
    input  logic [15:0]                           cam_kernels_x,
    input  logic [15:0]                           cam_lines_y,
    input  logic                                  frame_ack,
    output logic                                  mem_wr_en,
    output logic [ADDR_W-1:0]                     mem_wr_address,
    output logic [spot_finder_pkg::RAM_WORD_W-1:0] mem_wr_data,
    output logic                                  frame_rdy,
    output logic                                  overrun
);
    import spot_finder_pkg::*;

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    state_t            state;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W:0]   word_total;
    logic [ADDR_W:0]   frame_words;
    logic [31:0]       frame_area;
    logic              capture_valid;
    logic              packer_clear;
    logic              word_full;

    // Oversized frames are clamped so the address never wraps onto word 0.
    assign frame_area  = {16'd0, cam_kernels_x} * {16'd0, cam_lines_y};
    assign frame_words = (frame_area > MAX_WORDS) ? MAX_WORDS[ADDR_W:0] : frame_area[ADDR_W:0];

    assign capture_valid = pixel_valid &&
                           ((state == ST_CAPTURE) ||
                            ((state == ST_IDLE) && frame_start && (frame_words != '0)));
    assign packer_clear  = frame_start && (state != ST_DONE);

    pixel_packer #(
        .PIXELS_PER_WORD (PIXELS_PER_WORD)
    ) u_packer (
        .clk_in      (clk_in),
        .reset       (reset),
        .clear       (packer_clear),
        .pixel_in    (pixel_in),
        .pixel_valid (capture_valid),
        .pack_word   (mem_wr_data),
        .word_full   (word_full)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            word_count     <= '0;
            word_total     <= '0;
            mem_wr_en      <= 1'b0;
            mem_wr_address <= '0;
            frame_rdy      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        word_count <= '0;
                        word_total <= frame_words;
                        if (frame_words == '0) begin
                            state     <= ST_DONE;
                            frame_rdy <= 1'b1;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    // Completion wins over a late frame_start so a finished frame is never thrown away.
                    if (mem_wr_en && (word_count == word_total)) begin
                        state     <= ST_DONE;
                        frame_rdy <= 1'b1;
                    end else if (frame_start) begin
                        overrun    <= 1'b1;
                        word_count <= '0;
                        word_total <= frame_words;
                        if (frame_words == '0) begin
                            state     <= ST_DONE;
                            frame_rdy <= 1'b1;
                        end
                    end else if (word_full) begin
                        mem_wr_en      <= 1'b1;
                        mem_wr_address <= word_count[ADDR_W-1:0];
                        word_count     <= word_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (frame_ack) begin
                        state     <= ST_IDLE;
                        frame_rdy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spot_ram_writer.md
SPOT_RAM_WRITER -- requirements
Module: spot_ram_writer

Interface
REQ-001 SHALL have parameter PIXELS_PER_WORD, default 32, pixels packed per 256-bit RAM word (one kernel).
REQ-002 SHALL have parameter ADDR_W, default 14, RAM word-address width.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset is asynchronous and active-low.
REQ-005 SHALL have port pixel_in  input  8  camera pixel brightness.
REQ-006 SHALL have port pixel_valid  input  1  pixel_in valid this cycle.
REQ-007 SHALL have port frame_start  input  1  single-cycle pulse, first pixel of a frame follows (same cycle allowed).
REQ-008 SHALL have port cam_kernels_x  input  16  kernels per line (640 px -> 20).
REQ-009 SHALL have port cam_lines_y  input  16  lines per frame (480).
REQ-010 SHALL have port frame_ack  input  1  consumer (spot finder analysis_rdy) finished with buffer.
REQ-011 SHALL have port mem_wr_en  output  1  RAM write strobe.
REQ-012 SHALL have port mem_wr_address  output  ADDR_W  RAM word address.
REQ-013 SHALL have port mem_wr_data  output  256  packed kernel.
REQ-014 SHALL have port frame_rdy  output  1  level: complete frame in RAM.
REQ-015 SHALL have port overrun  output  1  sticky: frame_start arrived mid-capture.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, DONE; reset enters IDLE.
REQ-017 IDLE: ignore pixel_valid; on frame_start -> CAPTURE, word counter, pixel counter cleared; cam_kernels_x*cam_lines_y latched as frame word total (ADDR_W+1 bits).
REQ-018 A pixel_valid coinciding with the frame_start that causes IDLE->CAPTURE SHALL be captured as pixel 0.
REQ-019 CAPTURE: each valid pixel with pixel index n (0..31) SHALL be written into shift/pack register bits [8n+7:8n]; pixel 0 at LSB.
REQ-020 On the 32nd pixel of a word, mem_wr_en SHALL pulse high exactly one cycle, the next cycle, with mem_wr_data = packed word and mem_wr_address = word count; word count then increments.
REQ-021 Gaps in pixel_valid SHALL stall packing without loss; back-to-back pixels every cycle SHALL be sustained.
REQ-022 After the write of word (total-1): -> DONE, frame_rdy set the same cycle mem_wr_en falls; further pixels ignored.
REQ-023 DONE: hold frame_rdy high and mem_wr_en low; on frame_ack high -> IDLE, frame_rdy cleared next cycle.
REQ-024 frame_start during CAPTURE SHALL restart capture at address 0 (partial word discarded) and set overrun until reset.
REQ-025 frame_start during DONE SHALL be ignored (buffer protected until ack); overrun not set.
REQ-026 Total of 0 (either dimension 0) SHALL go IDLE->DONE directly with no writes.
REQ-027 Total > 2^ADDR_W SHALL clamp to 2^ADDR_W words; address never wraps.
REQ-028 mem_wr_address SHALL hold its last value when mem_wr_en is low.

Reset
REQ-029 Reset low SHALL asynchronously force: state IDLE, mem_wr_en 0, mem_wr_address 0, mem_wr_data 0, frame_rdy 0, overrun 0, counters 0.
REQ-030 Reset mid-capture SHALL discard the partial frame; no write strobe SHALL occur in the cycle of reset deassertion.

Structure
REQ-031 State encoding, PIXELS_PER_WORD, ADDR_W and RAM word width 256 SHALL live in shared package spot_finder_pkg, also used by main_spot_finder.
REQ-032 Pixel packing (counter + 256-bit pack register + word-complete flag) SHALL be sub-module pixel_packer; FSM and addressing in top.

Verification
REQ-033 kernels_x=2, lines_y=1, 64 pixels value=index, continuous -> writes addr0 data bytes 0..31, addr1 bytes 32..63, then frame_rdy=1.
REQ-034 Same frame with pixel_valid toggling 1/0 -> identical writes, frame_rdy after 2nd write.
REQ-035 frame_start after 40 pixels of kernels_x=2 frame -> overrun=1, next write at addr0 with the 32 new pixels.
REQ-036 In DONE, frame_start + 32 pixels -> no mem_wr_en; frame_ack -> frame_rdy=0 after 1 cycle, IDLE.
REQ-037 Reset low during 20th pixel of word 3 -> all outputs 0 immediately; no write on release.
REQ-038 kernels_x=20, lines_y=480, random pixels -> 9600 writes, addresses 0..9599, data matches scoreboard.
